// File: rtl/ekf_spi_cmd_deframer.sv
// SPI byte-stream deframer: cmd, len, len x DATA_WIDTH words -> {cmd,len,data} beats through a small FIFO.
// Optional macro EKF_FRAME_CRC_EN: a trailing CRC-8 byte gates release of the whole frame.
module ekf_spi_cmd_deframer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_frame_active,
  input  logic [7:0]            i_rx_byte,
  input  logic                  i_rx_valid,
  output logic [7:0]            o_cmd,
  output logic [7:0]            o_payload_length,
  output logic [DATA_WIDTH-1:0] o_payload_data,
  output logic                  o_payload_valid,
  input  logic                  i_payload_ready,
  output logic                  o_overflow,
  output logic                  o_frame_err,
  input  logic                  i_clr_status
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = 16 + DATA_WIDTH;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_P = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_DATA, S_DONE, S_RESYNC, S_CRC} state_t;
`ifdef EKF_FRAME_CRC_EN
  localparam state_t S_TAIL = S_CRC;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t                r_state;
  logic                  r_fa_d;
  logic [7:0]            r_cmd, r_len, r_word_cnt;
  logic [BCW-1:0]        r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_push_vld;
  logic [EW-1:0]         r_push_beat;
  logic [EW-1:0]         r_mem [FIFO_DEPTH];
  logic [AW:0]           r_rd_ptr, r_wr_ptr, r_wr_spec;
  logic                  r_overflow, r_frame_err;

  logic                  w_byte, w_rise, w_pop, w_full, w_push_ok, w_drop, w_abort, w_crc_bad;
  logic [AW:0]           w_used;
  logic [DATA_WIDTH-1:0] w_word_next;
  logic [EW-1:0]         w_head;

  assign w_byte      = i_rx_valid && i_frame_active;
  assign w_rise      = i_frame_active && !r_fa_d;
  assign w_word_next = (r_word << 8) | DATA_WIDTH'(i_rx_byte);
  assign w_used      = r_wr_spec - r_rd_ptr;
  assign w_full      = (w_used == DEPTH_P);
  assign w_pop       = o_payload_valid && i_payload_ready;
  assign w_push_ok   = r_push_vld && (!w_full || w_pop);
  assign w_drop      = r_push_vld && w_full && !w_pop;
  assign w_abort     = !i_frame_active && ((r_state == S_CMD) || (r_state == S_LEN) ||
                                           (r_state == S_DATA) || (r_state == S_CRC));

`ifdef EKF_FRAME_CRC_EN
  logic [7:0] r_crc;
  logic       w_commit, w_rollback;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  assign w_crc_bad  = (r_state == S_CRC) && w_byte && (i_rx_byte != r_crc);
  assign w_commit   = (r_state == S_CRC) && w_byte && (i_rx_byte == r_crc);
  assign w_rollback = w_abort || w_crc_bad || w_drop;

  // running CRC over cmd, len and data bytes of the current frame
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_crc <= 8'h00;
    else if (r_state == S_IDLE) r_crc <= 8'h00;
    else if (w_byte && ((r_state == S_CMD) || (r_state == S_LEN) || (r_state == S_DATA)))
      r_crc <= crc8_byte(r_crc, i_rx_byte);
  end
`else
  assign w_crc_bad = 1'b0;
`endif

  // parser FSM; a dropped beat forces RESYNC so the rest of the frame is discarded
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_fa_d      <= 1'b1;  // a frame already active at reset release must not look like a rise
      r_cmd       <= 8'h00;
      r_len       <= 8'h00;
      r_word_cnt  <= 8'h00;
      r_byte_cnt  <= '0;
      r_word      <= '0;
      r_push_vld  <= 1'b0;
      r_push_beat <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_fa_d     <= i_frame_active;
      r_push_vld <= 1'b0;
      if (w_drop) r_overflow <= 1'b1;
      else if (i_clr_status) r_overflow <= 1'b0;
      if (w_abort || w_crc_bad) r_frame_err <= 1'b1;
      else if (i_clr_status) r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: if (w_rise) r_state <= S_CMD;
        S_CMD: begin
          if (!i_frame_active) r_state <= S_IDLE;
          else if (w_byte) begin
            r_cmd   <= i_rx_byte;
            r_state <= S_LEN;
          end
        end
        S_LEN: begin
          if (!i_frame_active) r_state <= S_IDLE;
          else if (w_byte) begin
            r_len       <= i_rx_byte;
            r_word_cnt  <= 8'h00;
            r_byte_cnt  <= '0;
            r_push_vld  <= 1'b1;
            r_push_beat <= {r_cmd, i_rx_byte, {DATA_WIDTH{1'b0}}};
            r_state     <= (i_rx_byte == 8'h00) ? S_TAIL : S_DATA;
          end
        end
        S_DATA: begin
          if (!i_frame_active) r_state <= S_IDLE;
          else if (w_byte) begin
            r_word <= w_word_next;
            if (r_byte_cnt == BCW'(BYTES - 1)) begin
              r_byte_cnt  <= '0;
              r_push_vld  <= 1'b1;
              r_push_beat <= {r_cmd, r_len, w_word_next};
              r_word_cnt  <= r_word_cnt + 8'd1;
              if (r_word_cnt == r_len - 8'd1) r_state <= S_TAIL;
            end else begin
              r_byte_cnt <= r_byte_cnt + BCW'(1);
            end
          end
        end
`ifdef EKF_FRAME_CRC_EN
        S_CRC: begin
          if (!i_frame_active) r_state <= S_IDLE;
          else if (w_byte) r_state <= S_DONE;
        end
`endif
        S_DONE, S_RESYNC: if (!i_frame_active) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_drop && i_frame_active) begin
        r_state    <= S_RESYNC;
        r_push_vld <= 1'b0;
      end
    end
  end

  // beat FIFO; with CRC enabled r_wr_spec runs ahead of the visible tail until commit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_wr_spec <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push_ok) r_mem[r_wr_spec[AW-1:0]] <= r_push_beat;
`ifdef EKF_FRAME_CRC_EN
      if (w_rollback) r_wr_spec <= r_wr_ptr;
      else if (w_push_ok) r_wr_spec <= r_wr_spec + PTR_ONE;
      if (w_commit) r_wr_ptr <= w_push_ok ? (r_wr_spec + PTR_ONE) : r_wr_spec;
`else
      if (w_push_ok) begin
        r_wr_spec <= r_wr_spec + PTR_ONE;
        r_wr_ptr  <= r_wr_ptr + PTR_ONE;
      end
`endif
    end
  end

  assign w_head           = r_mem[r_rd_ptr[AW-1:0]];
  assign o_cmd            = w_head[EW-1 -: 8];
  assign o_payload_length = w_head[EW-9 -: 8];
  assign o_payload_data   = w_head[DATA_WIDTH-1:0];
  assign o_payload_valid  = (r_wr_ptr != r_rd_ptr);
  assign o_overflow       = r_overflow;
  assign o_frame_err      = r_frame_err;
endmodule

// File: tb/tb_ekf_spi_cmd_deframer.sv
// Bench for ekf_spi_cmd_deframer (default build): vector table, corner sequences, random frames vs a frame-level model.
module tb_ekf_spi_cmd_deframer;
  logic        clk, rst, fa, rx_valid, ready, clr;
  logic [7:0]  rx_byte, cmd_o, len_o;
  logic [31:0] data_o;
  logic        valid_o, ovf_o, err_o;

  ekf_spi_cmd_deframer #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_active(fa), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
    .o_cmd(cmd_o), .o_payload_length(len_o), .o_payload_data(data_o), .o_payload_valid(valid_o),
    .i_payload_ready(ready), .o_overflow(ovf_o), .o_frame_err(err_o), .i_clr_status(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [95:0] bytes;
    bit          junk;
    int          exp_beats;
    bit          exp_err;
  } vec_t;

  vec_t        tab [8];
  logic [7:0]  fb [40];
  logic [47:0] exp_q [$];
  int          n_checks = 0, n_pass = 0, n_beats = 0, base;
  int          rlen, rfull, rn;
  bit          rand_ready = 1'b0, m_err;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // scoreboard: every accepted beat must match the model's next expected beat
  always @(negedge clk) begin
    if (!rst && valid_o && ready) begin
      n_beats++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL beat: got unexpected %0h expected none", {cmd_o, len_o, data_o});
      end else begin
        check("beat", {16'h0, cmd_o, len_o, data_o}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // frame-level model: header once len arrives, one beat per complete word, error if cut short
  function automatic void model_frame(input int n, output bit err);
    int len;
    if (n < 2) begin
      err = 1'b1;
      return;
    end
    len = int'(fb[1]);
    exp_q.push_back({fb[0], fb[1], 32'h0});
    for (int w = 0; w < len; w++)
      if (n >= 2 + 4 * (w + 1))
        exp_q.push_back({fb[0], fb[1], fb[2+4*w], fb[3+4*w], fb[4+4*w], fb[5+4*w]});
    err = (n < 2 + 4 * len);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_byte = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic run_frame(input int n, input bit junk);
    fa = 1'b1;
    if (junk) begin
      rx_byte = 8'h77;
      rx_valid = 1'b1;
    end
    tick();
    rx_valid = 1'b0;
    tick();
    for (int i = 0; i < n; i++) send_byte(fb[i], $urandom_range(1, 3));
    repeat (2) tick();
    fa = 1'b0;
    repeat (3) tick();
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      tick();
      k++;
    end
    repeat (3) tick();
    check(nm, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
  endtask

  task automatic load_vec(input int t);
    for (int i = 0; i < 12; i++) fb[i] = tab[t].bytes[95-8*i -: 8];
  endtask

  initial begin
    tab[0] = '{n: 2,  bytes: 96'h1000_0000_0000_0000_0000_0000, junk: 1'b0, exp_beats: 1, exp_err: 1'b0};
    tab[1] = '{n: 10, bytes: 96'h0102_DEAD_BEEF_0102_0304_0000, junk: 1'b0, exp_beats: 3, exp_err: 1'b0};
    tab[2] = '{n: 4,  bytes: 96'h0302_AABB_0000_0000_0000_0000, junk: 1'b0, exp_beats: 1, exp_err: 1'b1};
    tab[3] = '{n: 2,  bytes: 96'h1100_0000_0000_0000_0000_0000, junk: 1'b1, exp_beats: 1, exp_err: 1'b0};
    tab[4] = '{n: 8,  bytes: 96'h2101_CAFE_BABE_5566_0000_0000, junk: 1'b0, exp_beats: 2, exp_err: 1'b0};
    tab[5] = '{n: 0,  bytes: 96'h0000_0000_0000_0000_0000_0000, junk: 1'b0, exp_beats: 0, exp_err: 1'b1};
    tab[6] = '{n: 1,  bytes: 96'h4400_0000_0000_0000_0000_0000, junk: 1'b0, exp_beats: 0, exp_err: 1'b1};
    tab[7] = '{n: 7,  bytes: 96'h0703_1122_3344_5500_0000_0000, junk: 1'b0, exp_beats: 2, exp_err: 1'b1};

    rst = 1'b1; fa = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; ready = 1'b1; clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_head", {16'h0, cmd_o, len_o, data_o}, 64'd0);
    check("reset_flags", 64'({ovf_o, err_o}), 64'd0);

    for (int t = 0; t < 8; t++) begin
      load_vec(t);
      base = n_beats;
      model_frame(tab[t].n, m_err);
      run_frame(tab[t].n, tab[t].junk);
      drain($sformatf("vec%0d_drain", t));
      check($sformatf("vec%0d_beats", t), 64'(n_beats - base), 64'(tab[t].exp_beats));
      check($sformatf("vec%0d_frame_err", t), 64'(err_o), 64'(tab[t].exp_err));
      check($sformatf("vec%0d_overflow", t), 64'(ovf_o), 64'd0);
      clr_pulse();
      check($sformatf("vec%0d_clr", t), 64'(err_o), 64'd0);
    end

    // overflow: consumer stalled, len=8 frame; header + 3 words fit, 4th word is dropped
    ready = 1'b0;
    fb[0] = 8'h02; fb[1] = 8'h08;
    for (int k = 0; k < 32; k++) fb[2+k] = 8'(k + 1);
    base = n_beats;
    model_frame(14, m_err);
    run_frame(34, 1'b0);
    check("ovf_flag", 64'(ovf_o), 64'd1);
    check("ovf_no_frame_err", 64'(err_o), 64'd0);
    check("ovf_head_cmd", 64'({valid_o, cmd_o}), 64'h102);
    ready = 1'b1;
    drain("ovf_drain");
    check("ovf_beats", 64'(n_beats - base), 64'd4);
    clr_pulse();
    check("ovf_clr", 64'(ovf_o), 64'd0);
    load_vec(1);
    base = n_beats;
    model_frame(10, m_err);
    run_frame(10, 1'b0);
    drain("ovf_next_drain");
    check("ovf_next_beats", 64'(n_beats - base), 64'd3);

    // full FIFO: the last word's push lands in the same cycle as a pop
    ready = 1'b0;
    fb[0] = 8'h05; fb[1] = 8'h04;
    for (int k = 0; k < 16; k++) fb[2+k] = 8'(8'hA0 + k);
    base = n_beats;
    model_frame(18, m_err);
    fa = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 17; i++) send_byte(fb[i], 2);
    rx_byte = fb[17]; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    check("fullpop_one_pop", 64'(n_beats - base), 64'd1);
    check("fullpop_no_ovf", 64'(ovf_o), 64'd0);
    fa = 1'b0;
    repeat (2) tick();
    ready = 1'b1;
    drain("fullpop_drain");
    check("fullpop_beats", 64'(n_beats - base), 64'd5);
    check("fullpop_err", 64'(err_o), 64'd0);

    // clear and a new error in the same cycle: the error wins
    fa = 1'b1;
    repeat (2) tick();
    fa = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check("clr_vs_err", 64'(err_o), 64'd1);
    clr_pulse();

    // reset mid-frame: FIFO flushed, rest of the frame ignored until a new rise
    ready = 1'b0;
    fa = 1'b1;
    repeat (2) tick();
    send_byte(8'h0A, 1); send_byte(8'h02, 1); send_byte(8'h11, 1); send_byte(8'h22, 1);
    check("prerst_valid", 64'(valid_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst_flush", 64'({valid_o, cmd_o}), 64'd0);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h33 + 8'h11 * i), 1);
    check("rst_ignored", 64'(valid_o), 64'd0);
    fa = 1'b0;
    repeat (2) tick();
    check("rst_no_err", 64'({ovf_o, err_o}), 64'd0);
    ready = 1'b1;
    load_vec(0);
    base = n_beats;
    model_frame(2, m_err);
    run_frame(2, 1'b0);
    drain("rst_next_drain");
    check("rst_next_beats", 64'(n_beats - base), 64'd1);

    // random frames against the frame-level model
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      rlen = $urandom_range(0, 4);
      rfull = 2 + 4 * rlen;
      fb[0] = 8'($urandom);
      fb[1] = 8'(rlen);
      for (int i = 2; i < 40; i++) fb[i] = 8'($urandom);
      rn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rfull - 1)) : rfull + int'($urandom_range(0, 2));
      model_frame(rn, m_err);
      run_frame(rn, 1'($urandom_range(0, 1)));
      drain("rnd_drain");
      check("rnd_frame_err", 64'(err_o), 64'(m_err));
      clr_pulse();
    end
    check("rnd_overflow", 64'(ovf_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
